// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcodes, instruction field positions, and the
// opcode-to-class helper used by the decode/issue stage.
package cpu_pkg;

    localparam int DW    = 16;
    localparam int NREGS = 16;

    localparam int OP_LSB = 12;
    localparam int A_LSB  = 8;
    localparam int B_LSB  = 4;
    localparam int C_LSB  = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
        OP_SHL  = 4'b0100, OP_SHR  = 4'b0101, OP_ROL  = 4'b0110, OP_ROR  = 4'b0111,
        OP_NOT  = 4'b1000, OP_BEQ  = 4'b1001, OP_BNE  = 4'b1010, OP_BLT  = 4'b1011,
        OP_LD   = 4'b1100, OP_ST   = 4'b1101, OP_NOP  = 4'b1110, OP_HALT = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        CL_RTYPE, CL_SHIFT, CL_BRANCH, CL_LOAD, CL_STORE, CL_NOP, CL_HALT
    } iclass_e;

    function automatic iclass_e instr_class(input logic [3:0] op);
        if (op <= OP_OR)       return CL_RTYPE;
        else if (op <= OP_NOT) return CL_SHIFT;
        else if (op <= OP_BLT) return CL_BRANCH;
        else if (op == OP_LD)  return CL_LOAD;
        else if (op == OP_ST)  return CL_STORE;
        else if (op == OP_NOP) return CL_NOP;
        else                   return CL_HALT;
    endfunction

endpackage

// File: rtl/regfile_16x16.sv
// 16x16 register file: two combinational read ports, one synchronous write
// port; R0 is hardwired to zero.
module regfile_16x16
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    ra_i,
    input  logic [3:0]    rb_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o,
    input  logic          we_i,
    input  logic [3:0]    waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [NREGS-1:0][DW-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i && waddr_i != 4'd0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (ra_i == 4'd0) ? '0 : mem_q[ra_i];
    assign rdata_b_o = (rb_i == 4'd0) ? '0 : mem_q[rb_i];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage with per-register scoreboard ahead of the ALU.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data.
module decode_issue
    import cpu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [15:0]   id_instr,
    output logic          id_ready,
    output logic          ex_valid,
    input  logic          ex_ready,
    output logic [3:0]    ex_aluop,
    output logic [DW-1:0] ex_rs,
    output logic [DW-1:0] ex_rt,
    output logic [3:0]    ex_imm4,
    output logic          ex_wen,
    output logic [3:0]    ex_wdest,
    input  logic          wb_en,
    input  logic [3:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          halted
);

    typedef enum logic {ST_RUN, ST_HALTED} state_e;

    state_e           state_q;
    logic             ex_valid_q, ex_wen_q;
    logic [3:0]       ex_aluop_q, ex_imm4_q, ex_wdest_q;
    logic [DW-1:0]    ex_rs_q, ex_rt_q;
    logic [NREGS-1:0] sb_q, sb_d, sb_eff, wb_mask;

    logic [3:0] op, fa, fb, fc, src0, src1;
    logic       use0, use1, wen, hazard, accept, issue, byp0, byp1;
    logic [DW-1:0] rd0, rd1, rs_d, rt_d;
    iclass_e    cls;

    assign op  = id_instr[OP_LSB +: 4];
    assign fa  = id_instr[A_LSB +: 4];
    assign fb  = id_instr[B_LSB +: 4];
    assign fc  = id_instr[C_LSB +: 4];
    assign cls = instr_class(op);

    always_comb begin
        src0 = fb;
        src1 = fc;
        use0 = 1'b0;
        use1 = 1'b0;
        wen  = 1'b0;
        case (cls)
            CL_RTYPE:  begin use0 = 1'b1; use1 = 1'b1; wen = 1'b1; end
            CL_SHIFT:  begin use0 = 1'b1; wen = 1'b1; end
            CL_BRANCH: begin src0 = fa; src1 = fb; use0 = 1'b1; use1 = 1'b1; end
            CL_LOAD:   begin use0 = 1'b1; wen = 1'b1; end
            CL_STORE:  begin src1 = fa; use0 = 1'b1; use1 = 1'b1; end
            default:   ;
        endcase
    end

    regfile_16x16 u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_i      (src0),
        .rb_i      (src1),
        .rdata_a_o (rd0),
        .rdata_b_o (rd1),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

`ifdef DECODE_WB_BYPASS_EN
    // A register retiring this cycle is treated as already written.
    assign wb_mask = wb_en ? (NREGS'(1) << wb_addr) : '0;
    assign byp0    = wb_en && wb_addr == src0 && src0 != 4'd0;
    assign byp1    = wb_en && wb_addr == src1 && src1 != 4'd0;
`else
    assign wb_mask = '0;
    assign byp0    = 1'b0;
    assign byp1    = 1'b0;
`endif

    assign sb_eff = sb_q & ~wb_mask;
    assign hazard = (use0 && sb_eff[src0]) || (use1 && sb_eff[src1]) || (wen && sb_eff[fa]);
    assign rs_d   = !use0 ? '0 : (byp0 ? wb_data : rd0);
    assign rt_d   = !use1 ? '0 : (byp1 ? wb_data : rd1);

    assign id_ready = (!ex_valid_q || ex_ready) && !hazard && state_q == ST_RUN;
    assign accept   = id_valid && id_ready;
    assign issue    = accept && cls != CL_NOP && cls != CL_HALT;

    // Clear on retire first so a same-cycle set for that register wins.
    always_comb begin
        sb_d = sb_q;
        if (wb_en) sb_d[wb_addr] = 1'b0;
        if (issue && wen) sb_d[fa] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            sb_q       <= '0;
            ex_valid_q <= 1'b0;
            ex_aluop_q <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_imm4_q  <= '0;
            ex_wen_q   <= 1'b0;
            ex_wdest_q <= '0;
        end else begin
            sb_q <= sb_d;
            if (issue) begin
                ex_valid_q <= 1'b1;
                ex_aluop_q <= op;
                ex_rs_q    <= rs_d;
                ex_rt_q    <= rt_d;
                ex_imm4_q  <= fc;
                ex_wen_q   <= wen;
                ex_wdest_q <= wen ? fa : 4'd0;
            end else if (ex_ready) begin
                ex_valid_q <= 1'b0;
            end
            case (state_q)
                ST_RUN:     if (accept && cls == CL_HALT) state_q <= ST_HALTED;
                ST_HALTED:  state_q <= ST_HALTED;
                default:    state_q <= ST_RUN;
            endcase
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_aluop = ex_aluop_q;
    assign ex_rs    = ex_rs_q;
    assign ex_rt    = ex_rt_q;
    assign ex_imm4  = ex_imm4_q;
    assign ex_wen   = ex_wen_q;
    assign ex_wdest = ex_wdest_q;
    assign halted   = state_q == ST_HALTED;

endmodule

// File: doc/decode_issue.md
# decode_issue

Decode/issue stage sitting directly upstream of the ALU. Accepts 16-bit instructions from fetch over a valid/ready handshake, decodes the opcode into the ALU's 4-bit operation select, reads the 16x16 register file, and presents registered operands (`rs`, `rt`, `imm4`) plus writeback tags to the execute stage. A per-register scoreboard stalls issue on read-after-write (RAW) and write-after-write (WAW) hazards until the writeback port retires the pending write.

## Interface
Parameters:
- `NREGS`, 16: register count; fixed by the 4-bit register fields.
- `DW`, 16: datapath width.

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `id_valid`  in  1: fetch presents an instruction.
- `id_instr`  in  16: instruction; fields are `[15:12]` op, `[11:8]` A, `[7:4]` B, `[3:0]` C.
- `id_ready`  out  1: instruction accepted this cycle when `id_valid` is also high.
- `ex_valid`  out  1: execute bundle valid.
- `ex_ready`  in  1: execute consumes the bundle.
- `ex_aluop`  out  4: ALU operation select.
- `ex_rs`, `ex_rt`  out  16: operands.
- `ex_imm4`  out  4: field C.
- `ex_wen`  out  1: instruction writes a register.
- `ex_wdest`  out  4: destination register.
- `wb_en`  in  1: writeback strobe.
- `wb_addr`  in  4: writeback register.
- `wb_data`  in  16: writeback data.
- `halted`  out  1: the stage has accepted HALT.

## Operation
- Operand mapping by opcode:
  - R-type (0000–0011): `ex_rs`=R[B], `ex_rt`=R[C], wdest=A, wen=1.
  - Shift/rotate/not (0100–1000): `ex_rs`=R[B], `ex_rt`=0, `imm4`=C, wdest=A, wen=1.
  - Branch (1001–1011): `ex_rs`=R[A], `ex_rt`=R[B], `imm4`=C (offset), wen=0.
  - Load (1100): `ex_rs`=R[B], `imm4`=C, wdest=A, wen=1.
  - Store (1101): `ex_rs`=R[B] (base), `ex_rt`=R[A] (data), `imm4`=C, wen=0.
  - 1110 NOP: accepted, consumed, produces no bundle.
  - 1111 HALT: accepted, consumed, produces no bundle.
- `ex_aluop` equals op for 0000–1101.
- R0 always reads 0. Writes to R0 are ignored, and R0 is never marked pending.
- Hazard: any source register of the instruction is pending, or its destination is pending (wen=1 only).
- `id_ready = (!ex_valid || ex_ready) && !hazard && state==RUN`.
- On accept with wen=1 and dest≠0, set the scoreboard bit for the destination.
- On `wb_en` with addr≠0, write the register and clear its scoreboard bit.
- If the same register is set and cleared in the same cycle, set wins.
- Two-state machine:
  - RUN: default state.
  - HALTED: entered from RUN when a HALT is accepted.
  - HALTED is left only by reset.
  - In HALTED, `id_ready`=0, while `ex_valid` and writeback still drain normally.

## Timing
- Reset values:
  - `ex_valid`=0 and all other `ex_*` outputs 0.
  - `halted`=0.
  - All registers and scoreboard bits 0.
  - State RUN.
- Latency: an instruction accepted at edge N appears on `ex_*` after edge N; `ex_valid`=1 in cycle N+1.
- The output bundle holds stable while `ex_valid && !ex_ready`.
- Back-to-back issue runs at one instruction per cycle when there is no hazard and `ex_ready`=1.
- `wb_en` is never back-pressured, and writes take effect at the edge.
- Reset asserted mid-stall or mid-drain clears everything immediately. The in-flight bundle is lost.
- `id_valid` low leaves all state unchanged apart from the writeback path.

## Configuration
- Macro `DECODE_WB_BYPASS_EN`.
- Defined: a register being written this cycle (`wb_en`, matching `wb_addr`) counts as not pending for the hazard check, and its operand is taken from `wb_data`. A dependent instruction can issue in the same cycle as the writeback.
- Undefined: no bypass. The hazard holds for that cycle, and the instruction issues one cycle after the writeback and reads the register file.

## Structure
- Shared package `cpu_pkg` holds:
  - typedef enum `opcode_e` (4-bit, values 0000–1111);
  - field position constants;
  - `DW` and `NREGS` localparams;
  - the `instr_class` helper function.
- Sub-module `regfile_16x16`: 2 combinational read ports, 1 synchronous write port, R0 hardwired to zero, asynchronous active-low reset.

## Test plan
- Reset, write R1=0x0005 and R2=0x0003 via `wb`, then issue 0x0312 (add R3,R1,R2) -> next cycle `ex_valid`=1, aluop=0, rs=5, rt=3, wen=1, wdest=3.
- Issue 0x0312 then 0x1431 (sub R4,R3,R1) with no writeback -> `id_ready`=0 on the second instruction until `wb_en` for R3. With bypass it issues in the writeback cycle with rs=`wb_data`; without bypass it issues one cycle later.
- Hold `ex_ready`=0 for 3 cycles after an issue -> bundle held constant, `id_ready`=0, and a second instruction is accepted in the cycle `ex_ready` rises.
- Issue 0xE000 then 0xF000 -> neither produces `ex_valid`; `halted`=1 the cycle after HALT is accepted, and `id_ready` stays 0 with `id_valid`=1 for 10 cycles.
- Issue 0x0500 (wdest R5) and in the same cycle `wb_en` R5 from an older write -> scoreboard bit 5 remains set; a following read of R5 stalls.
- Assert `rst_n` low while `ex_valid`=1 and the scoreboard is non-empty -> `ex_valid`=0, scoreboard clear and `halted`=0 immediately, with no clock edge needed.
